// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant mux that sits downstream of the round-robin arbiter.
package arb_pkg;

  // Ownership state of the output channel: free for arbitration, or held by one packet.
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_e;

  // Widest request vector the one-hot checker accepts; narrower vectors are zero-extended.
  localparam int MaxRequests = 64;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  // Zero-extension keeps one-hotness, so callers pass a cast of their own narrower vector.
  function automatic logic is_onehot(input logic [MaxRequests-1:0] vec);
    return (vec != '0) && ((vec & (vec - MaxRequests'(1))) == '0);
  endfunction

endpackage

// File: rtl/arb_grant_mux_onehot_to_index.sv
// Converts a grant vector into a binary requester index; the lowest set bit wins.
module onehot_to_index
  import arb_pkg::*;
#(
  parameter int NumRequests = 8,
  localparam int IdxWidth = idx_width(NumRequests)
) (
  input  logic [NumRequests-1:0] onehot,
  output logic [IdxWidth-1:0]    index,
  output logic                   valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = NumRequests - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        index = IdxWidth'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_grant_mux.sv
// Shares one registered output channel between N valid/ready requesters using an external
// round-robin arbiter, holds ownership for multi-beat packets and flags bad grants.
module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int NumRequests = 8,
  parameter int DataWidth = 32,
  localparam int IdxWidth = idx_width(NumRequests)
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic [NumRequests-1:0]                in_valid,
  output logic [NumRequests-1:0]                in_ready,
  input  logic [NumRequests-1:0][DataWidth-1:0] in_data,
  input  logic [NumRequests-1:0]                in_last,
  output logic [NumRequests-1:0]                arb_req,
  input  logic [NumRequests-1:0]                arb_grant,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DataWidth-1:0]                  out_data,
  output logic                                  out_last,
  output logic [IdxWidth-1:0]                   out_index,
  output logic                                  err
);

  lock_state_e          state_q, state_d;
  logic [IdxWidth-1:0]  lock_idx_q, lock_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [IdxWidth-1:0]  out_index_q, out_index_d;
  logic                 err_q, err_d;

  logic                   accept;
  logic                   grant_bad;
  logic                   grant_valid;
  logic                   xfer;
  logic [IdxWidth-1:0]    grant_idx;
  logic [IdxWidth-1:0]    sel_idx;
  logic [NumRequests-1:0] lock_onehot;

  // The slice can take a beat when empty or being drained this cycle.
  assign accept = !out_valid_q || out_ready;

  // Requests are withheld while locked or stalled so the arbiter's rotation does not advance.
  assign arb_req = (state_q == ST_IDLE && accept) ? in_valid : '0;

  assign lock_onehot = NumRequests'(1) << lock_idx_q;

  onehot_to_index #(
    .NumRequests(NumRequests)
  ) u_grant_idx (
    .onehot(arb_grant),
    .index (grant_idx),
    .valid (grant_valid)
  );

  // Grant checking, ready generation, payload mux and next-state for lock and output slice.
  always_comb begin
    in_ready    = '0;
    sel_idx     = lock_idx_q;
    xfer        = 1'b0;
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    err_d       = err_q;

    grant_bad = ((arb_grant != '0) || (arb_req != '0)) &&
                !(is_onehot(MaxRequests'(arb_grant)) && ((arb_grant & ~arb_req) == '0));

    if (state_q == ST_IDLE) begin
      sel_idx = grant_idx;
      if (accept && !grant_bad && grant_valid) begin
        in_ready = arb_grant;
      end
    end else if (accept) begin
      in_ready = lock_onehot;
    end

    xfer = |(in_valid & in_ready);

    if (grant_bad) begin
      err_d = 1'b1;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[sel_idx];
      out_last_d  = in_last[sel_idx];
      out_index_d = sel_idx;
      if (state_q == ST_IDLE && !in_last[sel_idx]) begin
        state_d    = ST_LOCKED;
        lock_idx_d = sel_idx;
      end else if (state_q == ST_LOCKED && in_last[sel_idx]) begin
        state_d = ST_IDLE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Packet ownership register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Registered output slice.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;
  assign err       = err_q;

endmodule
